// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// The line is registered, so it trails the FSM state by one clock.
module uart_tx #(
  parameter int CLKS_PER_BIT = 860,
  parameter int ADDR_W       = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [7:0]        dataIn,
  input  logic              dataValid,
  output logic              dataReady,
  output logic              serialOutput,
  output logic              busy,
  output logic [ADDR_W:0]   fifoCount
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [7:0]          mem [2**ADDR_W];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic [7:0]          shift;
  logic [2:0]          bit_idx;
  logic [BAUD_W-1:0]   baud_cnt;
  logic                baud_last, push, pop, line_next;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign dataReady = (count != DEPTH);
  assign push      = dataValid && dataReady;
  assign fifoCount = count;
  assign busy      = (state != IDLE) || (count != '0);

  // Next-state logic; a pop happens whenever a new frame is started.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (baud_last) state_next = DATA;
      DATA:  if (baud_last && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (baud_last) begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    line_next = 1'b1;
    case (state)
      START:   line_next = 1'b0;
      DATA:    line_next = shift[bit_idx];
      default: line_next = 1'b1;
    endcase
  end

  // State, FIFO bookkeeping, baud/bit counters and the registered line.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      serialOutput <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      shift        <= '0;
      bit_idx      <= '0;
      baud_cnt     <= '0;
    end else begin
      state        <= state_next;
      serialOutput <= line_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shift  <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (state == IDLE || baud_last) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)              bit_idx <= '0;
      else if (baud_last)             bit_idx <= bit_idx + 1'b1;
    end
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (resetN && push) mem[wr_ptr] <= dataIn;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT = 8: frame shape, latency,
// back-to-back frames, FIFO overflow, mid-frame reset and push-during-pop.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] dataIn;
  logic       dataValid;
  logic       dataReady;
  logic       serialOutput;
  logic       busy;
  logic [2:0] fifoCount;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs [4];
  logic [9:0] cap  [8];
  logic [7:0] burst [4];
  logic [7:0] ov    [6];
  int         peak;
  int         lows;

  uart_tx #(.CLKS_PER_BIT(8), .ADDR_W(2)) dut (
    .clk(clk),
    .resetN(resetN),
    .dataIn(dataIn),
    .dataValid(dataValid),
    .dataReady(dataReady),
    .serialOutput(serialOutput),
    .busy(busy),
    .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetDut;
    resetN    = 1'b0;
    dataValid = 1'b0;
    tick(2);
    resetN = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    dataIn    = d;
    dataValid = 1'b1;
    tick(1);
    dataValid = 1'b0;
  endtask

  // Call with time sitting inside the first start bit; samples every 8 clocks.
  task automatic captureFrames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < 10; b++) begin
        cap[f][b] = serialOutput;
        if (!(f == n - 1 && b == 9)) tick(8);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not end, %0d tests run", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Frame bit k is line bit k: start, d0..d7, stop.
    vecs[0] = '{8'h32, 10'b1001100100};
    vecs[1] = '{8'hA5, 10'b1101001010};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'hFF, 10'b1111111110};
    burst   = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
    ov      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state, with a write attempted while reset is asserted.
    resetN    = 1'b0;
    dataValid = 1'b1;
    dataIn    = 8'hAA;
    tick(2);
    checkOutput("rst_line", serialOutput, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", fifoCount, 0);
    checkOutput("rst_ready", dataReady, 1);
    dataValid = 1'b0;
    resetN    = 1'b1;
    tick(3);
    checkOutput("rst_ignored_count", fifoCount, 0);
    checkOutput("rst_ignored_busy", busy, 0);
    checkOutput("rst_ignored_line", serialOutput, 1);

    // Single frames from the table, with exact latency and busy timing.
    for (int i = 0; i < 4; i++) begin
      resetDut();
      applyStimulus(vecs[i].data);
      checkOutput("push_count", fifoCount, 1);
      tick(1);
      checkOutput("pre_fall_line", serialOutput, 1);
      checkOutput("popped_count", fifoCount, 0);
      tick(1);
      checkOutput("start_fall", serialOutput, 0);
      tick(4);
      captureFrames(1);
      checkOutput("frame", cap[0], vecs[i].frame);
      tick(2);
      checkOutput("busy_last_cycle", busy, 1);
      tick(1);
      checkOutput("busy_done", busy, 0);
      checkOutput("count_done", fifoCount, 0);
    end

    // Four bytes on consecutive cycles: contiguous frames, count peaks at 3.
    resetDut();
    dataValid = 1'b1;
    peak      = 0;
    for (int k = 0; k < 4; k++) begin
      dataIn = burst[k];
      tick(1);
      if (int'(fifoCount) > peak) peak = int'(fifoCount);
    end
    dataValid = 1'b0;
    checkOutput("burst_peak", peak, 3);
    tick(3);
    captureFrames(4);
    for (int k = 0; k < 4; k++)
      checkOutput("burst_frame", cap[k], {1'b1, burst[k], 1'b0});
    tick(2);
    checkOutput("burst_busy_end", busy, 1);
    tick(1);
    checkOutput("burst_idle", busy, 0);
    tick(20);
    checkOutput("burst_line_idle", serialOutput, 1);

    // Six bytes held valid: four fill the FIFO, the sixth is dropped.
    resetDut();
    dataValid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dataIn = ov[k];
      tick(1);
      if (k == 4) begin
        checkOutput("ov_full_count", fifoCount, 4);
        checkOutput("ov_full_ready", dataReady, 0);
      end
    end
    dataValid = 1'b0;
    checkOutput("ov_drop_count", fifoCount, 4);
    tick(1);
    captureFrames(5);
    for (int k = 0; k < 5; k++)
      checkOutput("ov_frame", cap[k], {1'b1, ov[k], 1'b0});
    tick(3);
    checkOutput("ov_idle_busy", busy, 0);
    checkOutput("ov_idle_count", fifoCount, 0);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (!serialOutput) lows++;
    end
    checkOutput("ov_no_sixth", lows, 0);

    // Reset during data bit 3 of 0xC3 with two bytes queued.
    resetDut();
    dataValid = 1'b1;
    dataIn    = 8'hC3;
    tick(1);
    dataIn = 8'h3C;
    tick(1);
    dataIn = 8'h96;
    tick(1);
    dataValid = 1'b0;
    tick(34);
    checkOutput("mid_queued", fifoCount, 2);
    checkOutput("mid_bit3", serialOutput, 0);
    checkOutput("mid_busy", busy, 1);
    resetN = 1'b0;
    tick(1);
    checkOutput("mid_rst_line", serialOutput, 1);
    checkOutput("mid_rst_count", fifoCount, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", dataReady, 1);
    resetN = 1'b1;
    lows   = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (!serialOutput) lows++;
    end
    checkOutput("mid_no_frames", lows, 0);
    checkOutput("mid_still_idle", busy, 0);

    // Push on the very edge the FSM pops with count = 1.
    resetDut();
    applyStimulus(8'h81);
    dataIn    = 8'h7E;
    dataValid = 1'b1;
    tick(1);
    dataValid = 1'b0;
    checkOutput("pushpop_count", fifoCount, 1);
    tick(5);
    captureFrames(2);
    checkOutput("pushpop_frame0", cap[0], 10'b1100000010);
    checkOutput("pushpop_frame1", cap[1], 10'b1011111100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter upstream of uArtRx. Accepts bytes on a valid/ready handshake and buffers them in a small FIFO.
- Drives the 8N1 line: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Its serialOutput connects directly to uArtRx serialInput, both for on-chip loopback and for the board link.
- Runs on the 100 MHz system clock from the clock module. The default timing gives the 8600 ns bit period uArtRx expects.

Parameters:
- CLKS_PER_BIT, 860, clk cycles per serial bit (860 x 10 ns = 8600 ns).
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W = 4 entries.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetN  input  1  synchronous, active-low reset.
- dataIn  input  8  byte to transmit.
- dataValid  input  1  dataIn is valid this cycle.
- dataReady  output  1  FIFO can accept a byte. Combinational: high when count != depth.
- serialOutput  output  1  UART line, idle high. Registered.
- busy  output  1  high when state != IDLE or count != 0.
- fifoCount  output  ADDR_W+1  number of bytes currently buffered.

Behaviour:
- Reset, sampled at a rising edge with resetN = 0:
  - serialOutput = 1, state = IDLE, FIFO pointers and count = 0, bit and baud counters = 0.
  - busy = 0, fifoCount = 0, dataReady = 1.
  - Writes presented while resetN = 0 are ignored.
- Push: at an edge where dataValid = 1 and dataReady = 1, dataIn is written at the write pointer, the write pointer increments (wrapping modulo depth) and count increments. dataValid is ignored when dataReady = 0; no overwrite, no error flag.
- Pop: the FSM takes the head byte into a shift register, the read pointer increments (wrapping) and count decrements.
- Push and pop in the same edge: count unchanged, both pointers advance. When the FIFO is full, push is blocked by dataReady = 0, but a pop in that cycle still occurs.
- FSM states:
  - IDLE: serialOutput = 1. If count > 0: pop, load the shift register, baud counter = 0, go to START.
  - START: serialOutput = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serialOutput = shift[bitIdx] for CLKS_PER_BIT cycles per bit. After bit 7 completes, go to STOP.
  - STOP: serialOutput = 1 for CLKS_PER_BIT cycles. At the end: if count > 0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0 to CLKS_PER_BIT-1; the bit advances when counter = CLKS_PER_BIT-1. Width is clog2(CLKS_PER_BIT).
- Latency: with the FIFO empty and the FSM in IDLE:
  - a byte accepted at edge N is popped at edge N+1;
  - serialOutput falls after edge N+2;
  - the stop bit ends 10 x CLKS_PER_BIT cycles after the line falls.
- Back-to-back frames are exactly 10 x CLKS_PER_BIT cycles each.
- The byte under transmission is held in the shift register and is unaffected by later pushes.
- Reset mid-frame: at the next edge with resetN = 0 the line returns to 1, the FIFO is flushed and the partial frame is abandoned.
- CLKS_PER_BIT must be >= 2; values below that are unsupported.

Test Plan:
- CLKS_PER_BIT = 8, push 0x32 once -> serialOutput low for 8 cycles, then bits 0,1,0,0,1,1,0,0 for 8 cycles each, then high for 8. busy falls 80 cycles after the start bit begins; fifoCount returns to 0.
- Default parameters, serialOutput looped to uArtRx serialInput, push 0x32 -> receiver dataOut = 0x32 after the stop bit, with no framing slip.
- CLKS_PER_BIT = 8, push 0xA5, 0x00, 0xFF, 0x5A on 4 consecutive cycles -> fifoCount peaks at 3. Four contiguous 80-cycle frames follow with no idle cycles between stop and start; line data is LSB first for each byte.
- CLKS_PER_BIT = 8, hold dataValid high with 6 distinct bytes on consecutive cycles:
  - 1st byte popped into the shift register; next 4 fill the FIFO; fifoCount = 4 and dataReady = 0, so the 6th byte is dropped.
  - Exactly 5 frames are transmitted, in order.
- Reset mid-frame during DATA bit 3 with 2 bytes queued -> next edge: serialOutput = 1, fifoCount = 0, busy = 0, dataReady = 1. No further frames until a new push.
- Push on the same cycle the FSM pops, with count = 1 -> fifoCount stays 1, and both bytes are transmitted in order.
